branch_predictor: RTL

Branch predictor for the MIPS pipeline: the fetch-side counterpart to the execute-stage branch resolution logic.
- Predicts direction and target for the PC in IF using a direct-mapped branch target buffer with 2-bit saturating counters.
- Takes the resolved outcome (branch-enable and computed target) back from EX, trains the table, and raises a registered redirect when the prediction was wrong.

---
 rtl/branch_predictor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: direct-mapped BTB with 2-bit counters.
// Trained from EX resolution; raises a registered redirect on mispredict.
module branch_predictor #(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic        init_done,
  output logic [31:0] br_count,
  output logic [31:0] mis_count
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_q, clr_d;

  logic               v_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic               run;
  logic [IDX_W-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic               l_hit, u_hit;
  logic               upd_en, mis;
  logic [31:0]        fix_pc;
  logic               unused;

  assign unused = ^if_pc[1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      S_INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == IDX_W'(ENTRIES - 1))
          state_d = S_RUN;
      end
      S_RUN: state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  assign run       = (state_q == S_RUN);
  assign init_done = run;

  assign l_idx = if_pc[IDX_W+1:2];
  assign l_tag = if_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  assign l_hit = run & v_q[l_idx] & (tag_q[l_idx] == l_tag);
  assign u_hit = v_q[u_idx] & (tag_q[u_idx] == u_tag);

  assign pred_taken  = l_hit & ctr_q[l_idx][1];
  assign pred_target = pred_taken ? tgt_q[l_idx] : '0;

  assign upd_en = upd_valid & run;
  assign mis    = (upd_taken != upd_pred_taken) |
                  (upd_taken & upd_pred_taken &
                   (upd_target != upd_pred_target));
  assign fix_pc = upd_taken ? upd_target : upd_pc + 32'd8;

  // Table has no reset of its own; INIT sweeps it one entry per cycle.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (!run) begin
        v_q[clr_q]   <= 1'b0;
        ctr_q[clr_q] <= 2'b01;
      end else if (upd_valid) begin
        if (u_hit) begin
          if (upd_taken) begin
            tgt_q[u_idx] <= upd_target;
            if (ctr_q[u_idx] != 2'b11)
              ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          end else if (ctr_q[u_idx] != 2'b00) begin
            ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
          end
        end else if (upd_taken) begin
          v_q[u_idx]   <= 1'b1;
          tag_q[u_idx] <= u_tag;
          tgt_q[u_idx] <= upd_target;
          ctr_q[u_idx] <= 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      br_count    <= '0;
      mis_count   <= '0;
    end else begin
      mispredict <= upd_en & mis;
      if (upd_en & mis)
        redirect_pc <= fix_pc;
      if (upd_en) begin
        if (br_count != '1)
          br_count <= br_count + 32'd1;
        if (mis && mis_count != '1)
          mis_count <= mis_count + 32'd1;
      end
    end
  end

endmodule
